// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern generator with its own H/V timing, four pattern
// modes, frame-latched scroll offset and mode, and fully registered outputs.
module vga_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int BPC        = 2,
   parameter int CHECK_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   input  logic [3:0]         speed,
   input  logic               dir,
   input  logic [3*BPC-1:0]   solid_rgb,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic [9:0]         pix_x,
   output logic [9:0]         pix_y,
   output logic [BPC-1:0]     R,
   output logic [BPC-1:0]     G,
   output logic [BPC-1:0]     B,
   output logic [7:0]         frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Position counters are 10 bits wide, so larger geometries cannot be represented.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
      $error("vga_pattern_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (BPC < 1 || BPC > 4 || CHECK_LOG2 < 0 || CHECK_LOG2 > 9) begin : g_bad_format
      $error("vga_pattern_gen: BPC must be 1..4 and CHECK_LOG2 0..9");
   end

   logic [9:0]       hpos_q, hpos_d;
   logic [9:0]       vpos_q, vpos_d;
   logic [9:0]       offset_q, offset_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             frame_end;

   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             display_on_q, display_on_d;
   logic [9:0]       pix_x_q, pix_x_d;
   logic [9:0]       pix_y_q, pix_y_d;
   logic [BPC-1:0]   r_q, r_d;
   logic [BPC-1:0]   g_q, g_d;
   logic [BPC-1:0]   b_q, b_d;

   logic [9:0]       mx;
   logic [3:0]       b_list;
   logic             checker_bit;
   logic             act;
   logic             unused_bits;

   // Mode, speed and direction are only sampled at frame_end so a frame never tears.
   always_comb begin
      frame_end   = (hpos_q == H_LAST) && (vpos_q == V_LAST);
      hpos_d      = hpos_q + 10'd1;
      vpos_d      = vpos_q;
      offset_d    = offset_q;
      frame_cnt_d = frame_cnt_q;
      mode_d      = mode_q;
      if (hpos_q == H_LAST) begin
         hpos_d = '0;
         vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
      end
      if (frame_end) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
         offset_d    = dir ? (offset_q - {6'd0, speed}) : (offset_q + {6'd0, speed});
         mode_d      = mode;
      end
   end

   always_comb begin
      mx           = hpos_q + offset_q;
      b_list       = {mx[7], vpos_q[5], 2'b00};
      checker_bit  = mx[CHECK_LOG2] ^ vpos_q[CHECK_LOG2];
      act          = (hpos_q < H_ACT_END) && (vpos_q < V_ACT_END);
      hsync_d      = ((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST)) ? H_POL : ~H_POL;
      vsync_d      = ((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST)) ? V_POL : ~V_POL;
      display_on_d = act;
      pix_x_d      = hpos_q;
      pix_y_d      = vpos_q;
      r_d          = '0;
      g_d          = '0;
      b_d          = '0;
      case (mode_q)
         2'd0: begin
            r_d = mx[5 +: BPC];
            g_d = mx[6 +: BPC];
            b_d = b_list[3 -: BPC];
         end
         2'd1: begin
            r_d = {BPC{checker_bit}};
            g_d = {BPC{checker_bit}};
            b_d = {BPC{checker_bit}};
         end
         2'd2: begin
            r_d = hpos_q[9 -: BPC];
            g_d = vpos_q[8 -: BPC];
            b_d = frame_cnt_q[7 -: BPC];
         end
         default: {r_d, g_d, b_d} = solid_rgb;
      endcase
      if (!act) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
   end

   assign unused_bits = ^{mx, b_list};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpos_q      <= '0;
         vpos_q      <= '0;
         offset_q    <= '0;
         frame_cnt_q <= '0;
         mode_q      <= '0;
      end else begin
         hpos_q      <= hpos_d;
         vpos_q      <= vpos_d;
         offset_q    <= offset_d;
         frame_cnt_q <= frame_cnt_d;
         mode_q      <= mode_d;
      end
   end

   // Every visible output registers the same hpos/vpos snapshot to stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q      <= ~H_POL;
         vsync_q      <= ~V_POL;
         display_on_q <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
      end else begin
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         display_on_q <= display_on_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
      end
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_on = display_on_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign R          = r_q;
   assign G          = g_q;
   assign B          = b_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken geometry, with directed
// checks at sync edges, frame boundaries, scroll wrap, mode latching and async reset.
module tb_vga_pattern_gen;

   localparam int HA = 264;
   localparam int HF = 8;
   localparam int HS = 16;
   localparam int HB = 12;
   localparam int HT = HA + HF + HS + HB;
   localparam int VA = 12;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int VT = VA + VF + VS + VB;
   localparam int CL = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic [3:0]  speed;
   logic        dir;
   logic [5:0]  solidRgb;
   logic        hsync;
   logic        vsync;
   logic        displayOn;
   logic [9:0]  pixX;
   logic [9:0]  pixY;
   logic [1:0]  rOut;
   logic [1:0]  gOut;
   logic [1:0]  bOut;
   logic [7:0]  frameCnt;
   logic [36:0] dutOuts;
   logic [5:0]  rgbOut;

   int compared   = 0;
   int mismatched = 0;

   int mH = 0;
   int mV = 0;
   int mOff = 0;
   int mFc = 0;
   int mMode = 0;
   logic [36:0] expQ[$];

   vga_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b1), .BPC(2), .CHECK_LOG2(CL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .dir(dir),
      .solid_rgb(solidRgb), .hsync(hsync), .vsync(vsync), .display_on(displayOn),
      .pix_x(pixX), .pix_y(pixY), .R(rOut), .G(gOut), .B(bOut), .frame_cnt(frameCnt)
   );

   assign dutOuts = {hsync, vsync, displayOn, pixX, pixY, rOut, gOut, bOut, frameCnt};
   assign rgbOut  = {rOut, gOut, bOut};

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [3:0] s, input logic d);
      mode  = m;
      speed = s;
      dir   = d;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput(tag, 64'(dutOuts), 64'({1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 6'd0, 8'd0}));
   endtask

   task automatic waitPix(input int x, input int y, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !found; i++) begin
         @(negedge clk);
         if (pixX == 10'(x) && pixY == 10'(y)) found = 1'b1;
      end
      checkOutput({tag, "_reached"}, 64'(found), 64'd1);
   endtask

   // Reference output for the pixel currently held in the model counters.
   function automatic logic [36:0] modelOut();
      int mx;
      logic hsE, vsE, deE, bitC;
      logic [1:0] r, g, b;
      mx  = (mH + mOff) % 1024;
      deE = (mH < HA) && (mV < VA);
      hsE = !((mH >= HA + HF) && (mH < HA + HF + HS));
      vsE = (mV >= VA + VF) && (mV < VA + VF + VS);
      r = 2'd0;
      g = 2'd0;
      b = 2'd0;
      case (mMode)
         0: begin
            r = 2'((mx / 32) % 4);
            g = 2'((mx / 64) % 4);
            b = 2'(2 * ((mx / 128) % 2) + (mV / 32) % 2);
         end
         1: begin
            bitC = 1'(((mx >> CL) ^ (mV >> CL)) & 1);
            r = bitC ? 2'd3 : 2'd0;
            g = r;
            b = r;
         end
         2: begin
            r = 2'((mH / 256) % 4);
            g = 2'((mV / 128) % 4);
            b = 2'((mFc / 64) % 4);
         end
         default: {r, g, b} = solidRgb;
      endcase
      if (!deE) begin
         r = 2'd0;
         g = 2'd0;
         b = 2'd0;
      end
      return {hsE, vsE, deE, 10'(mH), 10'(mV), r, g, b, 8'd0};
   endfunction

   // Model advances on every clock and pushes the output expected one edge later.
   initial begin
      logic [36:0] e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mH = 0; mV = 0; mOff = 0; mFc = 0; mMode = 0;
            expQ.delete();
         end else begin
            e = modelOut();
            if (mH == HT - 1) begin
               mH = 0;
               if (mV == VT - 1) begin
                  mV    = 0;
                  mFc   = (mFc + 1) % 256;
                  mOff  = dir ? (mOff + 1024 - int'(speed)) % 1024 : (mOff + int'(speed)) % 1024;
                  mMode = int'(mode);
               end else begin
                  mV++;
               end
            end else begin
               mH++;
            end
            e[7:0] = 8'(mFc);
            expQ.push_back(e);
         end
      end
   end

   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("scoreboard", 64'(dutOuts), 64'(e));
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      solidRgb = 6'h3F;
      applyStimulus(2'd3, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      checkResetValues("reset_init");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_pix_x", 64'(pixX), 64'd0);
      checkOutput("first_pix_y", 64'(pixY), 64'd0);
      checkOutput("first_de", 64'(displayOn), 64'd1);

      waitPix(263, 0, "de_last");
      checkOutput("de_263", 64'(displayOn), 64'd1);
      waitPix(264, 0, "de_off");
      checkOutput("de_264", 64'(displayOn), 64'd0);
      waitPix(271, 0, "hs_pre");
      checkOutput("hsync_271", 64'(hsync), 64'd1);
      waitPix(272, 0, "hs_first");
      checkOutput("hsync_272", 64'(hsync), 64'd0);
      waitPix(287, 0, "hs_last");
      checkOutput("hsync_287", 64'(hsync), 64'd0);
      waitPix(288, 0, "hs_post");
      checkOutput("hsync_288", 64'(hsync), 64'd1);
      waitPix(0, 12, "vs_pre");
      checkOutput("vsync_12", 64'(vsync), 64'd0);
      waitPix(0, 13, "vs_first");
      checkOutput("vsync_13", 64'(vsync), 64'd1);
      waitPix(0, 14, "vs_last");
      checkOutput("vsync_14", 64'(vsync), 64'd1);
      waitPix(0, 15, "vs_post");
      checkOutput("vsync_15", 64'(vsync), 64'd0);

      waitPix(298, 16, "pre_end");
      checkOutput("fc_before_end", 64'(frameCnt), 64'd0);
      @(negedge clk);
      checkOutput("fc_at_end", 64'(frameCnt), 64'd1);
      checkOutput("pix_at_end", 64'(pixX), 64'd299);

      // Frame 1: solid colour latched from the mode input at the end of frame 0.
      waitPix(16, 0, "solid");
      checkOutput("solid_rgb", 64'(rgbOut), 64'h3F);
      waitPix(270, 0, "blank");
      checkOutput("blank_rgb", 64'(rgbOut), 64'h00);
      applyStimulus(2'd0, 4'd3, 1'b0);

      for (int f = 0; f < 4; f++) waitPix(0, 0, "scroll_frame");
      waitPix(20, 0, "scroll");
      checkOutput("scroll_rgb", 64'(rgbOut), 64'h10);
      waitPix(0, 3, "mid_change");
      applyStimulus(2'd1, 4'd5, 1'b1);
      waitPix(20, 8, "no_tear");
      checkOutput("no_tear_rgb", 64'(rgbOut), 64'h10);

      for (int f = 0; f < 3; f++) waitPix(0, 0, "wrap_frame");
      waitPix(16, 0, "checker_on");
      checkOutput("checker_on_rgb", 64'(rgbOut), 64'h3F);
      waitPix(16, 4, "checker_off");
      checkOutput("checker_off_rgb", 64'(rgbOut), 64'h00);
      applyStimulus(2'd1, 4'd0, 1'b1);
      waitPix(0, 0, "freeze_frame");
      waitPix(16, 0, "freeze");
      checkOutput("freeze_rgb", 64'(rgbOut), 64'h3F);
      applyStimulus(2'd2, 4'd0, 1'b0);
      waitPix(0, 0, "grad_frame");
      waitPix(260, 0, "gradient");
      checkOutput("gradient_rgb", 64'(rgbOut), 64'h10);
      checkOutput("fc_frame10", 64'(frameCnt), 64'd10);

      waitPix(100, 5, "mid_reset");
      #1 rst_n = 1'b0;
      #1 checkResetValues("reset_async");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("restart_pix_x", 64'(pixX), 64'd0);
      checkOutput("restart_pix_y", 64'(pixY), 64'd0);
      checkOutput("restart_fc", 64'(frameCnt), 64'd0);
      waitPix(0, 2, "restart_run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised successor to the fixed 640x480 test-pattern top.
- Owns its own H/V timing counters, so sync geometry, sync polarity and colour depth are parameters.
- Adds four selectable pattern modes, a signed per-frame scroll speed, a solid-colour mode and a frame counter.
- Sits directly behind the TinyVGA PMOD output mapping. All outputs are registered and mutually aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
BPC, 2, bits per colour channel (1..4)
CHECK_LOG2, 4, checker square size is 2^CHECK_LOG2 pixels

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 scroll bars, 1 checker, 2 gradient, 3 solid
speed  in  4  scroll pixels per frame; 0 freezes the scroll
dir  in  1  scroll direction: 0 = offset increments, 1 = offset decrements
solid_rgb  in  3*BPC  colour used in mode 3, packed {R,G,B}
hsync  out  1  horizontal sync at H_POL level while asserted
vsync  out  1  vertical sync at V_POL level while asserted
display_on  out  1  high in the active area
pix_x  out  10  horizontal position, aligned with the colour outputs
pix_y  out  10  vertical position, aligned with the colour outputs
R  out  BPC  red channel
G  out  BPC  green channel
B  out  BPC  blue channel
frame_cnt  out  8  completed-frame count, wraps at 255

Behaviour:
Reset (async, rst_n low):
- hpos, vpos, offset, frame_cnt = 0; mode_q = 0.
- hsync = ~H_POL, vsync = ~V_POL; display_on = 0; R/G/B = 0; pix_x/pix_y = 0.
- Reset asserted mid-frame aborts the frame. After release, hpos starts counting from 0 on the first clk edge.

Counters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- hpos runs 0..H_TOTAL-1 and wraps. vpos increments on each hpos wrap and itself wraps after V_TOTAL-1.
- frame_end = (hpos==H_TOTAL-1 && vpos==V_TOTAL-1).

Per-frame update (on the frame_end cycle only):
- frame_cnt += 1.
- offset = offset ± speed, modulo 1024; + when dir=0, − when dir=1.
- mode_q <= mode. mode and speed changes mid-frame never tear a frame.

Decode from current hpos/vpos, registered with 1-cycle latency:
- hs_act = hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs_act is the vertical equivalent.
- hsync = hs_act ? H_POL : ~H_POL; vsync likewise.
- act = hpos<H_ACTIVE && vpos<V_ACTIVE.

Pattern, with mx = (hpos+offset) mod 1024:
- mode 0: R = mx[5+:BPC], G = mx[6+:BPC], B = {mx[7], vpos[5], ...}. B is filled MSB-first from that list and truncated or zero-padded to BPC bits.
- mode 1: all channels = {BPC{mx[CHECK_LOG2]^vpos[CHECK_LOG2]}}.
- mode 2: R = hpos[9-:BPC], G = vpos[8-:BPC], B = frame_cnt[7-:BPC].
- mode 3: {R,G,B} = solid_rgb.
- When act=0, R/G/B = 0 regardless of mode.

Registered-output alignment:
- pix_x, pix_y, display_on, hsync, vsync and R/G/B all register the same hpos/vpos state, so they stay mutually aligned.
- frame_cnt is the exception. It is the live counter, so it updates one cycle before the registered outputs reach the next frame.

Width rules:
- All position arithmetic is unsigned 10-bit and wraps silently.
- H_TOTAL and V_TOTAL must be ≤1024 (elaboration check).

Test Plan:
- Default params, release reset, run 800 clocks:
  - hsync low exactly on registered pix_x 656..751;
  - display_on high for pix_x 0..639 on line 0;
  - first registered output after reset has pix_x=0.
- Run one full frame (420000 clocks):
  - vsync low on lines 490..491 only;
  - frame_cnt steps 0→1 on the frame_end cycle;
  - R/G/B = 0 everywhere display_on=0 (solid_rgb=6'h3F, mode=3).
- mode=0, speed=3, dir=0, 4 frames: offset reads 12. Pixel at pix_x=20 shows R = mx[6:5] with mx=32, i.e. R=2'b01.
- dir=1, speed=5 from offset 0: after 1 frame offset = 1019 (wrap). speed=0 holds offset constant over 3 frames.
- Change mode 0→1 at line 100 mid-frame: no change in output until the pixel after frame_end. mode 1 gives R=G=B=2'b11 at (16,0) and 2'b00 at (16,16).
- Assert rst_n low at line 200, pixel 300, for 3 cycles: all outputs take reset values immediately (async), frame_cnt=0, and timing restarts from (0,0).
